// File: rtl/flash_sample_streamer.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_streamer
// Purpose  : Fetches little-endian 16-bit PCM samples from a parallel NOR
//            flash into a small FIFO and releases them to the codec at a
//            fixed sample rate. Supports start/stop, looping and volume.
// Ports    : clk, Reset_n            - clock, async active-low reset
//            start, stop             - playback control pulses
//            start_addr, end_addr    - first/last sample byte address
//            loop, volume            - wrap enable, right-shift amount
//            FL_ADDR, FL_OE_N, FL_DQ - flash bus
//            sample, sample_strobe   - codec sample and update pulse
//            busy, underrun          - playback / starvation status
// Revision : 1.0 - initial release
// ============================================================================
module flash_sample_streamer #(
  parameter int CLK_DIV     = 1042,
  parameter int WAIT_CYCLES = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [22:0] start_addr,
  input  logic [22:0] end_addr,
  input  logic        loop,
  input  logic [2:0]  volume,
  output logic [22:0] FL_ADDR,
  output logic        FL_OE_N,
  input  logic [7:0]  FL_DQ,
  output logic [15:0] sample,
  output logic        sample_strobe,
  output logic        busy,
  output logic        underrun
);

  localparam int c_PACE_W = $clog2(CLK_DIV + 1);
  localparam int c_WAIT_W = $clog2(WAIT_CYCLES + 1);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [c_PACE_W-1:0] c_PACE_LAST = c_PACE_W'(CLK_DIV - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [c_PTR_W:0]    c_FULL      = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_LO   = 3'd1,
    F_HI   = 3'd2,
    F_PUSH = 3'd3,
    F_DONE = 3'd4
  } fetch_state_t;

  fetch_state_t        r_state;
  logic [22:0]         r_addr;
  logic [c_WAIT_W-1:0] r_wait;
  logic [7:0]          r_lo;
  logic [7:0]          r_hi;
  logic                r_fetch_done;
  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic [c_PACE_W-1:0] r_pace;

  logic [22:0]        w_start_addr;
  logic [22:0]        w_end_addr;
  logic               w_tick;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic signed [15:0] w_scaled;
  logic               w_unused;

  // Samples are word aligned; the low address bit is not part of the range.
  assign w_start_addr = {start_addr[22:1], 1'b0};
  assign w_end_addr   = {end_addr[22:1], 1'b0};
  assign w_unused     = ^{start_addr[0], end_addr[0]};

  assign w_tick   = busy && (r_pace == c_PACE_LAST);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL);
  // A control pulse flushes the FIFO, so a push in that cycle is discarded.
  assign w_push   = (r_state == F_PUSH) && !start && !stop;
  assign w_pop    = w_tick && !w_empty;
  assign w_scaled = $signed(r_mem[r_rd_ptr]) >>> volume;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_hi, r_lo};
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= F_IDLE;
      r_addr        <= '0;
      r_wait        <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      r_fetch_done  <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_pace        <= '0;
      FL_ADDR       <= '0;
      FL_OE_N       <= 1'b1;
      sample        <= '0;
      sample_strobe <= 1'b0;
      busy          <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;

      if (stop) begin
        // Stop takes priority over a simultaneous start.
        busy     <= 1'b0;
        r_state  <= F_IDLE;
        FL_OE_N  <= 1'b1;
        r_wait   <= '0;
        r_pace   <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (start) begin
        // Restart from scratch; any read in flight is abandoned.
        busy         <= 1'b1;
        underrun     <= 1'b0;
        r_pace       <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_addr       <= w_start_addr;
        r_fetch_done <= 1'b0;
        r_state      <= F_IDLE;
        FL_OE_N      <= 1'b1;
        r_wait       <= '0;
      end else begin
        // Sample pacer
        if (busy) begin
          r_pace <= w_tick ? '0 : r_pace + 1'b1;
        end

        if (w_tick) begin
          if (!w_empty) begin
            r_rd_ptr      <= r_rd_ptr + 1'b1;
            sample        <= w_scaled;
            sample_strobe <= 1'b1;
          end else if (!r_fetch_done) begin
            underrun <= 1'b1;
          end else begin
            // Final strobe of a finished clip returns the codec to silence.
            busy          <= 1'b0;
            sample        <= '0;
            sample_strobe <= 1'b1;
          end
        end

        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase

        // Flash fetch sequencer
        case (r_state)
          F_IDLE: begin
            if (busy && !r_fetch_done && !w_full) begin
              r_state <= F_LO;
              FL_ADDR <= r_addr;
              FL_OE_N <= 1'b0;
              r_wait  <= '0;
            end
          end
          F_LO: begin
            if (r_wait == c_WAIT_LAST) begin
              r_lo    <= FL_DQ;
              FL_ADDR <= {r_addr[22:1], 1'b1};
              r_wait  <= '0;
              r_state <= F_HI;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          F_HI: begin
            if (r_wait == c_WAIT_LAST) begin
              r_hi    <= FL_DQ;
              FL_OE_N <= 1'b1;
              r_wait  <= '0;
              r_state <= F_PUSH;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          F_PUSH: begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            // ">=" also covers start_addr > end_addr: one sample, then done.
            if (r_addr >= w_end_addr) begin
              if (loop) begin
                r_addr  <= w_start_addr;
                r_state <= F_IDLE;
              end else begin
                r_fetch_done <= 1'b1;
                r_state      <= F_DONE;
              end
            end else begin
              r_addr  <= r_addr + 23'd2;
              r_state <= F_IDLE;
            end
          end
          F_DONE: begin
            r_state <= F_DONE;
          end
          default: begin
            r_state <= F_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
